// File: rtl/uart_alu_ctrl.sv
// Sequencer between the UART FIFOs and the ALU: pops a 3-byte frame
// (A, B, opcode), runs the ALU for one cycle and pushes the result byte.
// An inactivity timer discards partial frames so a lost byte cannot
// desynchronise the link.
//
// state   | meaning
// --------+-----------------------------------------------------
// WAIT_A  | idle, waiting for operand A byte
// WAIT_B  | A captured, waiting for operand B byte (timer runs)
// WAIT_OP | B captured, waiting for opcode byte (timer runs)
// EXEC    | ALU inputs stable, capture the result
// SEND    | hold result on w_data until the TX FIFO accepts it
module uart_alu_ctrl #(
  parameter int DBIT        = 8,
  parameter int OP_BITS     = 6,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int TO_BITS     = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_empty,
  input  logic [DBIT-1:0]    r_data,
  output logic               rd_uart,
  input  logic               tx_full,
  output logic [DBIT-1:0]    w_data,
  output logic               wr_uart,
  output logic [DBIT-1:0]    alu_a,
  output logic [DBIT-1:0]    alu_b,
  output logic [OP_BITS-1:0] alu_op,
  input  logic [DBIT-1:0]    alu_result,
  output logic               busy,
  output logic               timeout_err
);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND
  } state_t;

  // A zero TIMEOUT_CYC disables the timer; TO_LAST is then unused.
  localparam bit TO_EN = (TIMEOUT_CYC != 0);
  localparam logic [TO_BITS-1:0] TO_LAST =
    (TIMEOUT_CYC == 0) ? '0 : TO_BITS'(TIMEOUT_CYC - 1);

  state_t             state, state_next;
  logic [TO_BITS-1:0] to_cnt, to_cnt_next;
  logic [DBIT-1:0]    result_reg;

  // State, timer and datapath registers; operands only move on pops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= WAIT_A;
      to_cnt     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      result_reg <= '0;
    end else begin
      state  <= state_next;
      to_cnt <= to_cnt_next;
      if (rd_uart && state == WAIT_A)  alu_a  <= r_data;
      if (rd_uart && state == WAIT_B)  alu_b  <= r_data;
      if (rd_uart && state == WAIT_OP) alu_op <= r_data[OP_BITS-1:0];
      if (state == EXEC)               result_reg <= alu_result;
    end
  end

  // Next-state, FIFO strobes and timeout detection; a pop beats a timeout.
  always_comb begin
    state_next  = state;
    to_cnt_next = to_cnt;
    rd_uart     = 1'b0;
    wr_uart     = 1'b0;
    timeout_err = 1'b0;
    case (state)
      WAIT_A: begin
        to_cnt_next = '0;
        if (!rx_empty) begin
          rd_uart    = 1'b1;
          state_next = WAIT_B;
        end
      end
      WAIT_B, WAIT_OP: begin
        if (!rx_empty) begin
          rd_uart     = 1'b1;
          to_cnt_next = '0;
          state_next  = (state == WAIT_B) ? WAIT_OP : EXEC;
        end else if (TO_EN && to_cnt == TO_LAST) begin
          timeout_err = 1'b1;
          to_cnt_next = '0;
          state_next  = WAIT_A;
        end else if (TO_EN) begin
          to_cnt_next = to_cnt + TO_BITS'(1);
        end
      end
      EXEC: begin
        to_cnt_next = '0;
        state_next  = SEND;
      end
      SEND: begin
        to_cnt_next = '0;
        if (!tx_full) begin
          wr_uart    = 1'b1;
          state_next = WAIT_A;
        end
      end
      default: begin
        to_cnt_next = '0;
        state_next  = WAIT_A;
      end
    endcase
    // Strobes must stay low while reset is held even if the RX FIFO has data.
    if (!reset) begin
      rd_uart     = 1'b0;
      wr_uart     = 1'b0;
      timeout_err = 1'b0;
    end
  end

  // The result is presented continuously; busy covers the whole frame.
  always_comb begin
    w_data = result_reg;
    busy   = (state != WAIT_A);
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl: FIFO and ALU models, directed timing cases,
// then randomized frames checked against a transaction-level result queue.
module tb_uart_alu_ctrl;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic       tx_full = 1'b0;
  logic [7:0] w_data;
  logic       wr_uart;
  logic [7:0] alu_a, alu_b;
  logic [5:0] alu_op;
  logic [7:0] alu_result;
  logic       busy, timeout_err;

  logic [7:0] rxq[$];
  logic [7:0] expq[$];
  logic       stall = 1'b0;
  int         n_chk = 0;
  int         n_bad = 0;

  logic       s_rd, s_wr, s_busy, s_to;
  logic [7:0] s_wd, s_a, s_b;
  logic [5:0] s_op;

  uart_alu_ctrl #(.DBIT(8), .OP_BITS(6), .TIMEOUT_CYC(TO), .TO_BITS(4)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data),
    .rd_uart(rd_uart), .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      default: return a;
    endcase
  endfunction

  // Combinational ALU seen by the controller.
  always_comb alu_result = alu_ref(alu_a, alu_b, alu_op);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_rx();
    rx_empty = stall || (rxq.size() == 0);
    r_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
  endtask

  // One clock cycle: sample at negedge, then apply FIFO pop after posedge.
  task automatic cyc();
    logic [7:0] e;
    @(negedge clk);
    s_rd = rd_uart; s_wr = wr_uart; s_wd = w_data; s_busy = busy;
    s_to = timeout_err; s_a = alu_a; s_b = alu_b; s_op = alu_op;
    if (s_rd) check("rd_only_when_nonempty", rx_empty, 1'b0);
    if (s_wr) begin
      if (expq.size() == 0) check("unexpected_wr", s_wr, 1'b0);
      else begin
        e = expq.pop_front();
        check("tx_byte", s_wd, e);
      end
    end
    @(posedge clk); #1;
    if (s_rd && rxq.size() > 0) rxq.delete(0);
    drive_rx();
  endtask

  // Full frame with tx_full=0 and exact cycle timing n..n+4.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input bit push);
    logic [7:0] r;
    r = alu_ref(a, b, op[5:0]);
    if (push) begin
      rxq.push_back(a); rxq.push_back(b); rxq.push_back(op);
      expq.push_back(r);
    end
    drive_rx();
    cyc(); check("n_rd", s_rd, 1'b1); check("n_busy", s_busy, 1'b0);
    cyc(); check("n1_rd", s_rd, 1'b1); check("n1_busy", s_busy, 1'b1); check("alu_a", s_a, a);
    cyc(); check("n2_rd", s_rd, 1'b1); check("alu_b", s_b, b);
    cyc(); check("exec_rd", s_rd, 1'b0); check("exec_wr", s_wr, 1'b0);
    check("alu_op", s_op, op[5:0]);
    cyc(); check("send_wr", s_wr, 1'b1); check("send_wdata", s_wd, r);
    check("send_rd", s_rd, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd"}, rd_uart, 1'b0);
    check({tag, "_wr"}, wr_uart, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_to"}, timeout_err, 1'b0);
    check({tag, "_wdata"}, w_data, 8'h00);
    check({tag, "_abop"}, {alu_a, alu_b, 2'b00, alu_op}, 24'h0);
  endtask

  initial begin
    logic [7:0] a, b, op;
    int         nst;
    int         budget;
    logic [7:0] ops[5];
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26};
    drive_rx();
    #2 reset = 1'b0;
    #1 check_all_zero("reset_state");
    @(posedge clk); #1;
    reset = 1'b1;
    drive_rx();

    // Back-to-back frames and op byte masking.
    run_frame(8'h05, 8'h03, 8'h20, 1'b1);
    run_frame(8'h03, 8'h05, 8'hE2, 1'b1);
    run_frame(8'h0F, 8'h3C, 8'h24, 1'b1);

    // TX backpressure with the next frame already waiting in the RX FIFO.
    rxq = '{8'h10, 8'h20, 8'h25, 8'h01, 8'h02, 8'h20};
    expq.push_back(8'h30); expq.push_back(8'h03);
    tx_full = 1'b1;
    drive_rx();
    repeat (4) cyc();
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("bp_wr", s_wr, 1'b0);
      check("bp_rd", s_rd, 1'b0);
      check("bp_wdata", s_wd, 8'h30);
    end
    tx_full = 1'b0;
    cyc(); check("bp_release_wr", s_wr, 1'b1);
    run_frame(8'h01, 8'h02, 8'h20, 1'b0);

    // Timeout: frame starved after B.
    rxq = '{8'h11, 8'h22};
    drive_rx();
    cyc(); cyc(); check("to_b_pop", s_rd, 1'b1);
    for (int i = 0; i < TO - 1; i++) begin
      cyc(); check("to_early", s_to, 1'b0);
    end
    cyc(); check("to_pulse", s_to, 1'b1); check("to_pulse_busy", s_busy, 1'b1);
    cyc(); check("to_after", s_to, 1'b0); check("to_idle", s_busy, 1'b0);
    run_frame(8'h01, 8'h02, 8'h20, 1'b1);

    // Timeout race: opcode arrives in the last counted cycle.
    rxq = '{8'h11, 8'h22};
    expq.push_back(8'h33);
    drive_rx();
    cyc(); cyc();
    for (int i = 0; i < TO - 1; i++) cyc();
    rxq.push_back(8'h20);
    drive_rx();
    cyc(); check("race_pop", s_rd, 1'b1); check("race_to", s_to, 1'b0);
    cyc(); check("race_exec_busy", s_busy, 1'b1);
    cyc(); check("race_wr", s_wr, 1'b1);

    // Async reset mid-frame, with the B byte available.
    rxq = '{8'h05, 8'h03};
    drive_rx();
    cyc();
    #2 check("pre_reset_rd", rd_uart, 1'b1);
    reset = 1'b0;
    #1 check_all_zero("reset_midframe");
    rxq.delete();
    drive_rx();
    @(posedge clk); #1;
    reset = 1'b1;
    drive_rx();
    cyc(); check("post_reset1_busy", s_busy, 1'b0);

    // Async reset while stalled in SEND.
    rxq = '{8'h04, 8'h04, 8'h20};
    tx_full = 1'b1;
    drive_rx();
    repeat (6) cyc();
    check("stall_wdata", s_wd, 8'h08);
    check("stall_wr", s_wr, 1'b0);
    #2 reset = 1'b0;
    #1 check_all_zero("reset_send");
    tx_full = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    drive_rx();
    repeat (3) cyc();
    check("post_reset2_busy", s_busy, 1'b0);
    run_frame(8'h09, 8'h06, 8'h22, 1'b1);

    // Randomized frames with RX gaps and TX backpressure.
    for (int f = 0; f < 40; f++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ops[$urandom_range(0, 4)];
      op = op | (8'($urandom_range(0, 3)) << 6);
      rxq.push_back(a); rxq.push_back(b); rxq.push_back(op);
      expq.push_back(alu_ref(a, b, op[5:0]));
    end
    nst = 0;
    budget = 0;
    while (expq.size() > 0 && budget < 3000) begin
      stall = (nst < 3) && ($urandom_range(0, 2) == 0);
      nst = stall ? nst + 1 : 0;
      tx_full = ($urandom_range(0, 2) == 0);
      drive_rx();
      cyc();
      check("rand_no_timeout", s_to, 1'b0);
      budget++;
    end
    check("rand_drained", expq.size(), 0);
    stall = 1'b0;
    tx_full = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_alu_ctrl.md
# uart_alu_ctrl

Sequencing controller that sits between the UART (RX/TX FIFOs) and the ALU. It pops a 3-byte command frame from the RX FIFO: operand A, operand B, then opcode. It drives the ALU with the captured operands and opcode, latches the result, and pushes that result as one byte into the TX FIFO. An inactivity timeout discards partial frames, so a lost byte cannot desynchronise the link permanently.

## Interface
Parameters:
- DBIT, 8, data/operand width (equals UART data bits)
- OP_BITS, 6, ALU opcode width; taken from op byte bits [OP_BITS-1:0], upper bits ignored
- TIMEOUT_CYC, 1000000, max idle cycles allowed mid-frame; 0 disables timeout
- TO_BITS, 20, timeout counter width; TIMEOUT_CYC < 2^TO_BITS

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- rx_empty  in  1  RX FIFO empty
- r_data  in  DBIT  RX FIFO head word (valid when rx_empty=0)
- rd_uart  out  1  RX FIFO pop strobe
- tx_full  in  1  TX FIFO full
- w_data  out  DBIT  byte written to TX FIFO
- wr_uart  out  1  TX FIFO push strobe
- alu_a  out  DBIT  operand A register
- alu_b  out  DBIT  operand B register
- alu_op  out  OP_BITS  opcode register
- alu_result  in  DBIT  combinational ALU result
- busy  out  1  high whenever state != WAIT_A
- timeout_err  out  1  one-cycle pulse when a partial frame is discarded

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND.
- WAIT_A/WAIT_B/WAIT_OP with rx_empty=0:
  - rd_uart=1 combinationally.
  - alu_a / alu_b / alu_op loads r_data at the edge.
  - Advance to WAIT_B / WAIT_OP / EXEC respectively.
- Any WAIT state with rx_empty=1: rd_uart=0, hold.
- EXEC: one cycle; result_reg <= alu_result; go to SEND.
- SEND: w_data = result_reg at all times.
  - tx_full=0: wr_uart=1 combinationally, then go to WAIT_A.
  - tx_full=1: wr_uart=0, stay in SEND indefinitely (no timeout in SEND).
- rd_uart and wr_uart are never asserted outside the conditions above; each is at most one pulse per byte.
- Timeout counter:
  - Cleared on every pop and on entry to WAIT_A.
  - Increments each cycle in WAIT_B/WAIT_OP while rx_empty=1.
  - When it equals TIMEOUT_CYC-1 and rx_empty=1: next state WAIT_A, timeout_err=1 for that cycle, counter cleared.
  - If a byte arrives in that same cycle, the pop wins and there is no timeout.
  - alu_a/alu_b keep their partial values; the next frame overwrites them.
- TIMEOUT_CYC=0: counter is held at 0 and timeout_err never asserts.
- alu_a/alu_b/alu_op change only on pops, so the ALU inputs are stable through EXEC and SEND.
- Reset (async, any state, including mid-frame or in SEND with wr_uart pending):
  - State goes to WAIT_A.
  - alu_a, alu_b, alu_op, result_reg, counter cleared to 0.
  - rd_uart=0, wr_uart=0, busy=0, timeout_err=0, w_data=0.

## Timing
- Throughput: at most one RX pop per cycle; a fully buffered frame is consumed in 3 consecutive cycles (n, n+1, n+2).
- EXEC occurs in cycle n+3. wr_uart asserts in cycle n+4 if tx_full=0.
- Latency: 2 cycles from the opcode pop edge to wr_uart.
- Minimum frame period 5 cycles. The next frame's A byte may be popped in cycle n+5.
- busy rises the cycle after the A pop and falls the cycle after the wr_uart cycle.
- timeout_err is registered-state-derived and coincident with the transition cycle, not the cycle after.

## Test plan
- Back-to-back frames:
  - Stimulus: RX FIFO preloaded with 0x05, 0x03, 0x20 (ADD), ALU model adds.
  - Required: rd_uart high cycles n..n+2, alu_a=0x05, alu_b=0x03, alu_op=6'h20, wr_uart at n+4 with w_data=0x08, busy low at n+5.
- Op byte masking:
  - Stimulus: op byte 0xE2 with OP_BITS=6.
  - Required: alu_op=6'h22 (SUB); A=0x03, B=0x05 gives w_data=0xFE.
- TX backpressure:
  - Stimulus: tx_full=1 for 10 cycles in SEND.
  - Required: wr_uart=0 and w_data stable for those 10 cycles; single wr_uart pulse the cycle tx_full drops; no extra RX pops meanwhile.
- Timeout:
  - Stimulus: TIMEOUT_CYC=8; send only 0x11, 0x22, then starve the RX FIFO.
  - Required: timeout_err single pulse 8 cycles after the B pop; state returns to WAIT_A; next bytes 0x01, 0x02, 0x20 yield w_data=0x03.
- Timeout race:
  - Stimulus: a byte arrives exactly in the counter==TIMEOUT_CYC-1 cycle.
  - Required: pop occurs, timeout_err stays 0, frame continues.
- Async reset:
  - Stimulus: reset low mid-frame (after A pop) and again while stalled in SEND.
  - Required: all outputs 0 immediately (no clock edge needed), wr_uart never pulses, and a clean frame after release completes normally.
